// File: rtl/credit_award_scheduler.sv
// Credit-circle game state: per-credit values with hit cooldown, award/bonus queue to the score path.
// Build macro CREDIT_REGEN_EN: an emptied, ready credit refills to INIT_VALUE after REGEN_FRAMES frames.
module credit_award_scheduler #(
    parameter int NUM_CREDITS     = 4,
    parameter int INIT_VALUE      = 5,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int BONUS_AMOUNT    = 50,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] creditIndex,
    input  logic       collisionBallCredit,
    input  logic       reset_level_pulse,
    input  logic       startOfFrame,
    input  logic       awardReady,
    output logic [3:0] number,
    output logic       awardValid,
    output logic [7:0] awardAmount,
    output logic       allCollected,
    output logic [3:0] creditsLeft
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]  INIT_V  = 4'(INIT_VALUE);
    localparam logic [7:0]  COOL_V  = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0]  BONUS_V = 8'(BONUS_AMOUNT);
    localparam logic [PW:0] DEPTH_V = (PW + 1)'(FIFO_DEPTH);
`ifdef CREDIT_REGEN_EN
    localparam int REGEN_FRAMES = 600;
    localparam logic [9:0] REGEN_LAST = 10'(REGEN_FRAMES - 1);
`endif

    typedef enum logic {READY, COOL} credit_state_e;

    logic [NUM_CREDITS-1:0][3:0] value_all;
    logic [NUM_CREDITS-1:0]      nonzero;
    logic [NUM_CREDITS-1:0]      hit_vec;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          bonus_pending_q;
    logic          all_collected_q;
    logic [3:0]    credits_left_q;

    logic       hit_any, last_hit, full, pop, push, bonus_push;
    logic [7:0] push_data;

    // Value served to the digit bitmap; also the award for an accepted hit.
    always_comb begin
        number = 4'd0;
        for (int i = 0; i < NUM_CREDITS; i++) begin
            if (creditIndex == 4'(i)) number = value_all[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CREDITS; gi++) begin : g_credit
            logic [3:0]    val_q;
            logic [7:0]    cnt_q;
            credit_state_e st_q;
            logic          regen_done;

            assign value_all[gi] = val_q;
            assign nonzero[gi]   = (val_q != 4'd0);
            assign hit_vec[gi]   = collisionBallCredit && !reset_level_pulse &&
                                   (creditIndex == 4'(gi)) && nonzero[gi] && (st_q == READY);

`ifdef CREDIT_REGEN_EN
            logic [9:0] regen_q;
            assign regen_done = (st_q == READY) && !nonzero[gi] && startOfFrame &&
                                (regen_q == REGEN_LAST);

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    regen_q <= '0;
                end else if (reset_level_pulse || regen_done) begin
                    regen_q <= '0;
                end else if ((st_q == READY) && !nonzero[gi] && startOfFrame) begin
                    regen_q <= regen_q + 10'd1;
                end
            end
`else
            assign regen_done = 1'b0;
`endif

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    val_q <= INIT_V;
                    cnt_q <= '0;
                    st_q  <= READY;
                end else if (reset_level_pulse) begin
                    val_q <= INIT_V;
                    cnt_q <= '0;
                    st_q  <= READY;
                end else if (st_q == READY) begin
                    if (hit_vec[gi]) begin
                        val_q <= val_q - 4'd1;
                        cnt_q <= COOL_V;
                        st_q  <= COOL;
                    end else if (regen_done) begin
                        val_q <= INIT_V;
                    end
                end else if (startOfFrame) begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) st_q <= READY;
                end
            end
        end
    endgenerate

    // A credit award always wins the single push slot; a waiting bonus retries later.
    always_comb begin
        hit_any    = |hit_vec;
        last_hit   = hit_any && (number == 4'd1) && ((nonzero & ~hit_vec) == '0);
        full       = (count_q == DEPTH_V);
        awardValid = (count_q != '0);
        pop        = awardValid && awardReady;
        bonus_push = bonus_pending_q && !hit_any && !full && !reset_level_pulse;
        push       = (hit_any && !full) || bonus_push;
        push_data  = hit_any ? {4'd0, number} : BONUS_V;
        count_d    = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
        awardAmount = awardValid ? mem[rd_ptr_q] : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            bonus_pending_q <= 1'b0;
            all_collected_q <= 1'b0;
            credits_left_q  <= 4'(NUM_CREDITS);
        end else if (reset_level_pulse) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            bonus_pending_q <= 1'b0;
            all_collected_q <= 1'b0;
            credits_left_q  <= 4'(NUM_CREDITS);
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q         <= count_d;
            all_collected_q <= last_hit;
            if (last_hit)        bonus_pending_q <= 1'b1;
            else if (bonus_push) bonus_pending_q <= 1'b0;
            credits_left_q  <= 4'($countones(nonzero));
        end
    end

    assign allCollected = all_collected_q;
    assign creditsLeft  = credits_left_q;

endmodule

// File: tb/tb_credit_award_scheduler.sv
// Directed bench for credit_award_scheduler: per-cycle comparison against a queue-based game model.
module tb_credit_award_scheduler;
    localparam int NC    = 4;
    localparam int INIT  = 5;
    localparam int COOLF = 30;
    localparam int BONUS = 50;
    localparam int DEPTH = 4;
`ifdef CREDIT_REGEN_EN
    localparam int REGEN = 600;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [3:0] creditIndex = 4'd0;
    logic       collisionBallCredit = 1'b0;
    logic       reset_level_pulse = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       awardReady = 1'b0;
    logic [3:0] number;
    logic       awardValid;
    logic [7:0] awardAmount;
    logic       allCollected;
    logic [3:0] creditsLeft;

    int checks = 0;
    int errors = 0;

    credit_award_scheduler dut (
        .clk                 (clk),
        .resetN              (resetN),
        .creditIndex         (creditIndex),
        .collisionBallCredit (collisionBallCredit),
        .reset_level_pulse   (reset_level_pulse),
        .startOfFrame        (startOfFrame),
        .awardReady          (awardReady),
        .number              (number),
        .awardValid          (awardValid),
        .awardAmount         (awardAmount),
        .allCollected        (allCollected),
        .creditsLeft         (creditsLeft)
    );

    always #5 clk = ~clk;

    // Game model: remaining value, frames of cooldown left (0 = hittable), award queue.
    int m_val [NC];
    int m_cool [NC];
    int m_zero [NC];
    int fifo [$];
    bit m_pending;
    bit m_allc;
    int m_left;
    int got [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_val[i] = INIT; m_cool[i] = 0; m_zero[i] = 0;
        end
        fifo.delete();
        m_pending = 0;
        m_allc = 0;
        m_left = NC;
    endtask

    task automatic model_step();
        int pre_left, idx, others;
        bit hit, full, pop, bonus_now;
        pre_left = 0;
        for (int i = 0; i < NC; i++) if (m_val[i] != 0) pre_left++;
        if (reset_level_pulse) begin
            model_reset();
            return;
        end
        idx = int'(creditIndex);
        hit = collisionBallCredit && (idx < NC) && (m_val[idx] > 0) && (m_cool[idx] == 0);
        others = 0;
        for (int i = 0; i < NC; i++) if (i != idx && m_val[i] != 0) others++;
        full = fifo.size() >= DEPTH;
        pop = (fifo.size() > 0) && awardReady;
        bonus_now = m_pending && !hit && !full;
        if (pop) void'(fifo.pop_front());
        m_allc = 0;
        for (int i = 0; i < NC; i++) begin
            if (hit && i == idx) continue;
            if (m_cool[i] > 0) begin
                if (startOfFrame) m_cool[i]--;
            end
`ifdef CREDIT_REGEN_EN
            else if (m_val[i] == 0 && startOfFrame) begin
                m_zero[i]++;
                if (m_zero[i] == REGEN) begin
                    m_val[i] = INIT;
                    m_zero[i] = 0;
                end
            end
`endif
        end
        if (hit) begin
            if (!full) fifo.push_back(m_val[idx]);
            if (m_val[idx] == 1 && others == 0) begin
                m_allc = 1;
                m_pending = 1;
            end
            m_val[idx]--;
            m_cool[idx] = COOLF;
        end
        if (bonus_now) begin
            fifo.push_back(BONUS);
            m_pending = 0;
        end
        m_left = pre_left;
    endtask

    always @(posedge clk) begin
        if (!resetN) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        int e_num;
        if (resetN) begin
            e_num = (int'(creditIndex) < NC) ? m_val[creditIndex] : 0;
            chk("cmp_number", int'(number), e_num);
            chk("cmp_valid", int'(awardValid), int'(fifo.size() > 0));
            chk("cmp_amount", int'(awardAmount), (fifo.size() > 0) ? fifo[0] : 0);
            chk("cmp_allcollected", int'(allCollected), int'(m_allc));
            chk("cmp_creditsleft", int'(creditsLeft), m_left);
        end
    end

    // Record each handshake: outputs captured mid-cycle, accepted at the next edge.
    logic       sv_valid = 1'b0;
    logic [7:0] sv_amt = 8'd0;
    always @(negedge clk) begin
        sv_valid = awardValid;
        sv_amt = awardAmount;
    end
    always @(posedge clk) begin
        if (resetN && sv_valid && awardReady) got.push_back(int'(sv_amt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1; step();
            startOfFrame = 1'b0; steps(3);
        end
    endtask

    task automatic hit(input int idx);
        creditIndex = 4'(idx);
        collisionBallCredit = 1'b1; step();
        collisionBallCredit = 1'b0; step();
    endtask

    task automatic level_reset();
        reset_level_pulse = 1'b1; step();
        reset_level_pulse = 1'b0; step();
    endtask

    task automatic peek(input int idx, input string name, input int exp);
        @(negedge clk);
        creditIndex = 4'(idx);
        #1;
        chk(name, int'(number), exp);
    endtask

    function automatic int got_at(input int i);
        return (i < got.size()) ? got[i] : -1;
    endfunction

    initial begin
        int fives;
        model_reset();
        steps(3);
        resetN = 1'b1;
        step();

        @(negedge clk);
        $display("reset: valid=%0d amount=%0d allc=%0d left=%0d", awardValid, awardAmount, allCollected, creditsLeft);
        chk("reset_valid", int'(awardValid), 0);
        chk("reset_amount", int'(awardAmount), 0);
        chk("reset_allcollected", int'(allCollected), 0);
        chk("reset_creditsleft", int'(creditsLeft), 4);
        peek(0, "reset_number0", 5);
        peek(7, "number_out_of_range", 0);

        // T1: collision held on credit 2 across three frames -> one award.
        awardReady = 1'b1;
        creditIndex = 4'd2;
        collisionBallCredit = 1'b1;
        frames(3);
        collisionBallCredit = 1'b0;
        steps(3);
        $display("T1: awards=%0d first=%0d", got.size(), got_at(0));
        chk("t1_award_count", got.size(), 1);
        chk("t1_award", got_at(0), 5);
        peek(2, "t1_number2", 4);
        chk("t1_creditsleft", int'(creditsLeft), 4);

        // T2: cooldown covers frame 10, expired by frame 31.
        level_reset();
        got.delete();
        hit(0);
        frames(10);
        hit(0);
        frames(21);
        hit(0);
        steps(3);
        $display("T2: awards=%0d a0=%0d a1=%0d", got.size(), got_at(0), got_at(1));
        chk("t2_award_count", got.size(), 2);
        chk("t2_award0", got_at(0), 5);
        chk("t2_award1", got_at(1), 4);

        // T3: drain everything; last hit triggers allCollected and the bonus.
        level_reset();
        got.delete();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NC; i++) begin
                if (r == 4 && i == NC - 1) begin
                    creditIndex = 4'(i);
                    collisionBallCredit = 1'b1; step();
                    @(negedge clk);
                    chk("t3_allcollected_pulse", int'(allCollected), 1);
                    collisionBallCredit = 1'b0; step();
                    @(negedge clk);
                    chk("t3_allcollected_drop", int'(allCollected), 0);
                end else begin
                    hit(i);
                end
            end
            if (r < 4) frames(31);
        end
        steps(4);
        $display("T3: awards=%0d last=%0d bonus=%0d left=%0d", got.size(), got_at(19), got_at(20), creditsLeft);
        chk("t3_award_count", got.size(), 21);
        chk("t3_last_award", got_at(19), 1);
        chk("t3_bonus", got_at(20), 50);
        chk("t3_creditsleft", int'(creditsLeft), 0);

        // T4: stalled score path; fifth award dropped but credit still spent.
        level_reset();
        got.delete();
        awardReady = 1'b0;
        for (int i = 0; i < NC; i++) hit(i);
        frames(31);
        hit(0);
        peek(0, "t4_number0", 3);
        chk("t4_valid", int'(awardValid), 1);
        awardReady = 1'b1;
        steps(6);
        fives = 0;
        foreach (got[i]) if (got[i] == 5) fives++;
        $display("T4: awards=%0d fives=%0d", got.size(), fives);
        chk("t4_award_count", got.size(), 4);
        chk("t4_all_fives", fives, 4);

        // T5: level restart beats a simultaneous hit and flushes the queue.
        level_reset();
        got.delete();
        awardReady = 1'b0;
        hit(0);
        creditIndex = 4'd1;
        collisionBallCredit = 1'b1;
        reset_level_pulse = 1'b1;
        step();
        collisionBallCredit = 1'b0;
        reset_level_pulse = 1'b0;
        @(negedge clk);
        chk("t5_valid", int'(awardValid), 0);
        chk("t5_amount", int'(awardAmount), 0);
        peek(0, "t5_number0", 5);
        peek(1, "t5_number1", 5);
        awardReady = 1'b1;
        steps(4);
        $display("T5: awards=%0d", got.size());
        chk("t5_award_count", got.size(), 0);

`ifdef CREDIT_REGEN_EN
        // T6: an emptied credit refills after its cooldown plus the regen period.
        level_reset();
        got.delete();
        for (int r = 0; r < 5; r++) begin
            hit(1);
            frames(31);
        end
        peek(1, "t6_number1_empty", 0);
        frames(600);
        peek(1, "t6_number1_refilled", 5);
        got.delete();
        hit(1);
        steps(3);
        $display("T6: awards=%0d a0=%0d", got.size(), got_at(0));
        chk("t6_award_count", got.size(), 1);
        chk("t6_award", got_at(0), 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
